mux_arb: RTL and testbench

Round-robin arbiter and sequencer for the shared N-input output mux. It accepts valid/ready beat streams from N requesters and selects one requester at a time. It drives the mux select as a registered one-hot-or-zero vector and gates the per-requester ready from a single downstream ready. Grants are held for a whole packet, capped at a maximum burst length, so one requester cannot monopolise the mux.

---
 rtl/mux_arb.sv | 144 ++++++++++++++
 tb/tb_mux_arb.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mux_arb.sv
// Round-robin arbiter/sequencer for a shared N-input mux with a registered one-hot select.
// Define MUX_ARB_PKT_LOCK_EN to hold grants for whole packets (capped at MAX_BURST beats).
module mux_arb #(
  parameter int N         = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         i_req_vld,
  input  logic [N-1:0]         i_req_last,
  output logic [N-1:0]         o_req_rdy,
  output logic [N-1:0]         o_sel,
  output logic [$clog2(N)-1:0] o_sel_enc,
  output logic                 o_vld,
  input  logic                 i_rdy
);

  localparam int W = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sel_q, sel_d;
  logic [W-1:0]   enc_q, enc_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [W-1:0]   ptr_nxt;
  logic [W-1:0]   arb_ptr;
  logic [W:0]     arb_res;
  logic           arb_found;
  logic [W-1:0]   arb_idx;
  logic           xfer;
  logic           rel;

  // First valid index at or after ptr, wrapping modulo N; {found, index}.
  function automatic logic [W:0] rr_pick(input logic [N-1:0] vld, input logic [W-1:0] ptr);
    logic [W:0]   r;
    logic [W-1:0] idx_w;
    int           idx;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx   = (int'(ptr) + k) % N;
      idx_w = W'(idx);
      if (vld[idx_w]) r = {1'b1, idx_w};
    end
    return r;
  endfunction

  assign o_sel     = sel_q;
  assign o_sel_enc = enc_q;
  assign o_vld     = |(sel_q & i_req_vld);
  assign o_req_rdy = sel_q & {N{i_rdy}};
  assign xfer      = (state_q == GRANT) & o_vld & i_rdy;

  assign ptr_nxt   = (enc_q == W'(N - 1)) ? '0 : enc_q + 1'b1;
  // From IDLE arbitrate on the stored pointer; on release the just-served index drops to lowest priority.
  assign arb_ptr   = (state_q == GRANT) ? ptr_nxt : ptr_q;
  assign arb_res   = rr_pick(i_req_vld, arb_ptr);
  assign arb_found = arb_res[W];
  assign arb_idx   = arb_res[W-1:0];

`ifdef MUX_ARB_PKT_LOCK_EN
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  assign rel = xfer & ((|(sel_q & i_req_last)) | (cnt_q == CW'(MAX_BURST - 1)));
`else
  logic unused_cfg;

  assign unused_cfg = (^i_req_last) ^ (MAX_BURST > 256);
  assign rel        = xfer;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    enc_d   = enc_q;
    ptr_d   = ptr_q;
`ifdef MUX_ARB_PKT_LOCK_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = GRANT;
          sel_d   = {{(N-1){1'b0}}, 1'b1} << arb_idx;
          enc_d   = arb_idx;
`ifdef MUX_ARB_PKT_LOCK_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = ptr_nxt;
`ifdef MUX_ARB_PKT_LOCK_EN
          cnt_d = '0;
`endif
          if (arb_found) begin
            sel_d = {{(N-1){1'b0}}, 1'b1} << arb_idx;
            enc_d = arb_idx;
          end else begin
            state_d = IDLE;
            sel_d   = '0;
            enc_d   = '0;
          end
        end
`ifdef MUX_ARB_PKT_LOCK_EN
        else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        enc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      enc_q   <= '0;
      ptr_q   <= '0;
`ifdef MUX_ARB_PKT_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      enc_q   <= enc_d;
      ptr_q   <= ptr_d;
`ifdef MUX_ARB_PKT_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux_arb.sv
// Directed + random bench for mux_arb (N=4, MAX_BURST=4); expectations follow MUX_ARB_PKT_LOCK_EN.
module tb_mux_arb;
  localparam int N  = 4;
  localparam int MB = 4;
`ifdef MUX_ARB_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] i_req_vld, i_req_last, o_req_rdy, o_sel;
  logic [1:0]   o_sel_enc;
  logic         o_vld, i_rdy;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  mux_arb #(.N(N), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req_vld  (i_req_vld),
    .i_req_last (i_req_last),
    .o_req_rdy  (o_req_rdy),
    .o_sel      (o_sel),
    .o_sel_enc  (o_sel_enc),
    .o_vld      (o_vld),
    .i_rdy      (i_rdy)
  );

  function automatic logic [31:0] enc_of(input logic [N-1:0] s);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < N; i++) if (s[i]) r = i;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One directed cycle: drive inputs, queue expected select, compare at negedge.
  task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic rd, input logic [N-1:0] exp_sel, input string tag);
    logic [N-1:0] e;
    rst = r; i_req_vld = v; i_req_last = l; i_rdy = rd;
    exp_q.push_back(exp_sel);
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".sel"}, o_sel, e);
    check({tag, ".enc"}, o_sel_enc, enc_of(e));
    check({tag, ".rdy"}, o_req_rdy, e & {N{rd}});
    check({tag, ".vld"}, o_vld, |(e & v));
    $display("%-10s rst=%b vld=%b last=%b rdy=%b -> sel=%b enc=%0d req_rdy=%b o_vld=%b",
             tag, r, v, l, rd, o_sel, o_sel_enc, o_req_rdy, o_vld);
    @(posedge clk); #1;
  endtask

  int wait_cnt[N];
  int max_wait;

  initial begin
    rst = 1'b1; i_req_vld = '0; i_req_last = '0; i_rdy = 1'b0;
    @(posedge clk); #1;

    // reset state
    cycle(1, 4'b0000, 4'b0000, 0, 4'b0000, "rst0");
    cycle(1, 4'b1111, 4'b1111, 1, 4'b0000, "rst1");

    // single requester 2, three-beat packet
    cycle(0, 4'b0100, 4'b0000, 1, 4'b0000, "t1_idle");
    cycle(0, 4'b0100, 4'b0000, 1, 4'b0100, "t1_b1");
    cycle(0, 4'b0100, 4'b0000, 1, 4'b0100, "t1_b2");
    cycle(0, 4'b0100, 4'b0100, 1, 4'b0100, "t1_b3");
    cycle(0, 4'b0000, 4'b0000, 1, 4'b0100, "t1_hold");
    cycle(0, 4'b1111, 4'b1111, 1, 4'b0100, "t1_p3");

    // all valid, one-beat packets: pointer 3 after requester 2 -> 3,0,1,2,3
    cycle(0, 4'b1111, 4'b1111, 1, 4'b1000, "t2_g3");
    cycle(0, 4'b1111, 4'b1111, 1, 4'b0001, "t2_g0");
    cycle(0, 4'b1111, 4'b1111, 1, 4'b0010, "t2_g1");
    cycle(0, 4'b1111, 4'b1111, 1, 4'b0100, "t2_g2");
    cycle(0, 4'b1111, 4'b1111, 1, 4'b1000, "t2_g3b");
    cycle(0, 4'b1111, 4'b1111, 1, 4'b0001, "t3_pre");

    // requester 1 granted, downstream stalls for 5 cycles
    cycle(0, 4'b0010, 4'b0000, 1, 4'b0010, "t3_b1");
    for (int i = 0; i < 5; i++) cycle(0, 4'b1111, 4'b0000, 0, 4'b0010, "t3_stall");
    cycle(0, 4'b0110, 4'b0000, 1, 4'b0010, "t3_b2");
    cycle(0, 4'b0110, 4'b0000, 1, LOCK ? 4'b0010 : 4'b0100, "t3_b3");
    cycle(0, 4'b0110, 4'b0000, 1, 4'b0010, "t3_b4");

    // requester 0 long packet vs requester 2: burst cap
    cycle(0, 4'b0101, 4'b0100, 1, 4'b0100, "t4_pre");
    cycle(0, 4'b0101, 4'b0000, 1, 4'b0001, "t4_a");
    cycle(0, 4'b0101, 4'b0000, 1, LOCK ? 4'b0001 : 4'b0100, "t4_b");
    cycle(0, 4'b0101, 4'b0000, 1, 4'b0001, "t4_c");
    cycle(0, 4'b0101, 4'b0000, 1, LOCK ? 4'b0001 : 4'b0100, "t4_d");
    cycle(0, 4'b0101, 4'b0000, 1, LOCK ? 4'b0100 : 4'b0001, "t4_e");

    // reset mid-grant, then pointer restarts at 0
    cycle(1, 4'b0101, 4'b0000, 0, 4'b0100, "t5_rst");
    cycle(0, 4'b1010, 4'b0000, 0, 4'b0000, "t5_idle");
    cycle(0, 4'b1010, 4'b0000, 1, 4'b0010, "t5_win1");

    // random traffic: select/ready legality and bounded waiting
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      rst        = 1'b0;
      i_req_vld  = ($urandom_range(0, 9) < 8) ? N'($urandom) | 4'b0001 : N'($urandom);
      i_req_last = N'($urandom);
      i_rdy      = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      check("rnd.onehot_sel", $onehot0(o_sel), 1);
      check("rnd.rdy_in_sel", o_req_rdy & ~o_sel, 0);
      check("rnd.onehot_rdy", $onehot0(o_req_rdy), 1);
      max_wait = 0;
      for (int i = 0; i < N; i++) begin
        if (!i_req_vld[i] || o_sel[i]) wait_cnt[i] = 0;
        else if (o_vld && i_rdy) wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      check("rnd.starve", max_wait <= N * MB, 1);
      if (c % 500 == 0)
        $display("rnd%-7d vld=%b rdy=%b -> sel=%b max_wait=%0d", c, i_req_vld, i_rdy, o_sel, max_wait);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
